// File: rtl/fpga_link_receiver.sv
`default_nettype none
// ============================================================================
// Module   : fpga_link_receiver
// Brief    : Four-phase link receiver: beat assembly, word FIFO, valid/ready
//            drain after frame end. Optional WAIT timeout: FPGA_LINK_RX_TIMEOUT_EN
// Revision : 1.0
// ============================================================================
module fpga_link_receiver #(
  parameter int LANE_W  = 1,
  parameter int BEATS   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       send,
  input  logic                       finish,
  input  logic [LANE_W-1:0]          data_in,
  output logic                       acknowledge,
  output logic                       shift,
  output logic                       received,
  output logic                       word_valid,
  output logic [LANE_W*BEATS-1:0]    word_data,
  input  logic                       word_ready,
  output logic [$clog2(DEPTH+1)-1:0] frame_words,
  output logic                       err_overflow,
  output logic                       err_partial,
  output logic                       err_timeout
);

  localparam int WORD_W = LANE_W * BEATS;
  localparam int BCNT_W = $clog2(BEATS + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_RECV    = 3'd3,
    S_NEXT    = 3'd4,
    S_PROCESS = 3'd5,
    S_END     = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   sr_q, sr_d;
  logic [BCNT_W-1:0]   beat_q, beat_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    frame_q, frame_d;
  logic                err_ov_q, err_ov_d;
  logic                err_pt_q, err_pt_d;
  logic                ack_q, ack_d;
  logic                shift_q, shift_d;
  logic                recv_q, recv_d;
  logic                wvalid_q, wvalid_d;
  logic                push_en;
  logic [WORD_W-1:0]   shifted;

`ifdef FPGA_LINK_RX_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            err_to_q, err_to_d;
`endif

  // New beat enters at the top; after BEATS shifts the first beat sits in the LSBs.
  assign shifted = {data_in, sr_q[WORD_W-1:LANE_W]};

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    beat_d   = beat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    frame_d  = frame_q;
    err_ov_d = err_ov_q;
    err_pt_d = err_pt_q;
    push_en  = 1'b0;
`ifdef FPGA_LINK_RX_TIMEOUT_EN
    to_d     = '0;
    err_to_d = err_to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (send) begin
          state_d  = S_START;
          sr_d     = '0;
          beat_d   = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          frame_d  = '0;
          err_ov_d = 1'b0;
          err_pt_d = 1'b0;
`ifdef FPGA_LINK_RX_TIMEOUT_EN
          err_to_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (!send) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (send) begin
          state_d = S_RECV;
          sr_d    = shifted;
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (count_q == FULL_CNT) begin
              err_ov_d = 1'b1;
            end else begin
              // No pops happen mid-frame, so frame_q tracks count_q and cannot exceed DEPTH.
              push_en  = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              count_d  = count_q + 1'b1;
              frame_d  = frame_q + 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (finish) begin
          state_d = S_PROCESS;
          if (beat_q != '0) begin
            err_pt_d = 1'b1;
            beat_d   = '0;
          end
        end
`ifdef FPGA_LINK_RX_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          state_d  = S_IDLE;
          err_to_d = 1'b1;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          frame_d  = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      S_RECV: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (!send) state_d = S_WAIT;
      end
      S_PROCESS: begin
        if (count_q == '0) begin
          state_d = S_END;
        end else if (word_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
          if (count_q == ONE_CNT) state_d = S_END;
        end
      end
      S_END: begin
        if (!finish) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ack_d    = (state_d == S_START) || (state_d == S_NEXT) || (state_d == S_END);
    shift_d  = (state_d == S_RECV);
    recv_d   = (state_d == S_PROCESS);
    wvalid_d = (state_d == S_PROCESS) && (count_d != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      frame_q  <= '0;
      err_ov_q <= 1'b0;
      err_pt_q <= 1'b0;
      ack_q    <= 1'b0;
      shift_q  <= 1'b0;
      recv_q   <= 1'b0;
      wvalid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef FPGA_LINK_RX_TIMEOUT_EN
      to_q     <= '0;
      err_to_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      frame_q  <= frame_d;
      err_ov_q <= err_ov_d;
      err_pt_q <= err_pt_d;
      ack_q    <= ack_d;
      shift_q  <= shift_d;
      recv_q   <= recv_d;
      wvalid_q <= wvalid_d;
      if (push_en) mem_q[wr_ptr_q] <= shifted;
`ifdef FPGA_LINK_RX_TIMEOUT_EN
      to_q     <= to_d;
      err_to_q <= err_to_d;
`endif
    end
  end

  assign acknowledge  = ack_q;
  assign shift        = shift_q;
  assign received     = recv_q;
  assign word_valid   = wvalid_q;
  assign word_data    = mem_q[rd_ptr_q];
  assign frame_words  = frame_q;
  assign err_overflow = err_ov_q;
  assign err_partial  = err_pt_q;

`ifdef FPGA_LINK_RX_TIMEOUT_EN
  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
  // TIMEOUT only shapes logic in the timeout build; this empty block keeps it referenced.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

endmodule
`default_nettype wire
